// File: rtl/npc_unit_pkg.sv
// Shared encodings for the next-PC sequencer: npc_op selector and run/halt/fault states.
package npc_unit_pkg;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    NPC_ST_RUN   = 2'b00,
    NPC_ST_HALT  = 2'b01,
    NPC_ST_FAULT = 2'b10
  } npc_state_e;

  localparam logic [31:0] NPC_PC_RESET_DEF = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target, branch-taken and alignment check for the MIPS datapath.
// NPC_PERF_EN additionally exports the branch-taken decision for the event counters.
module npc_calc
  import npc_unit_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [1:0]      npc_op,
  input  logic            br_ne,
  input  logic            zero,
  input  logic [15:0]     imm16,
  input  logic [25:0]     jidx26,
  input  logic [PC_W-1:0] rs_val,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] target,
  output logic            misalign
`ifdef NPC_PERF_EN
  ,
  output logic            taken
`endif
);

  logic signed [PC_W-1:0] br_off;
  logic                   br_taken;

  assign pc_plus4 = pc + PC_W'(4);
  // Word offset scaled to bytes; sign extension lets the add wrap modulo 2^PC_W.
  assign br_off   = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  assign br_taken = br_ne ? ~zero : zero;

  always_comb begin
    target = pc_plus4;
    case (npc_op_e'(npc_op))
      NPC_BRANCH: if (br_taken) target = pc_plus4 + $unsigned(br_off);
      NPC_JUMP:   target = {pc_plus4[PC_W-1:PC_W-4], jidx26, 2'b00};
      NPC_JR:     target = rs_val;
      default:    target = pc_plus4;
    endcase
  end

  assign misalign = |target[1:0];

`ifdef NPC_PERF_EN
  assign taken = br_taken;
`endif

endmodule

// File: rtl/npc_unit.sv
// PC register and run/halt/fault sequencer; target selection lives in npc_calc.
// Define NPC_PERF_EN to add the br_taken_cnt / jump_cnt event counters.
module npc_unit
  import npc_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = NPC_PC_RESET_DEF,
  parameter int          PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_en,
  input  logic [1:0]      npc_op,
  input  logic            br_ne,
  input  logic            zero,
  input  logic [15:0]     imm16,
  input  logic [25:0]     jidx26,
  input  logic [PC_W-1:0] rs_val,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            halted,
  output logic            fault
`ifdef NPC_PERF_EN
  ,
  output logic [31:0]     br_taken_cnt,
  output logic [31:0]     jump_cnt
`endif
);

  npc_state_e      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] target;
  logic            misalign;
  logic            halted_q;
  logic            fault_q;
`ifdef NPC_PERF_EN
  logic            taken;
`endif

  npc_calc #(.PC_W(PC_W)) u_calc (
    .pc       (pc_q),
    .npc_op   (npc_op),
    .br_ne    (br_ne),
    .zero     (zero),
    .imm16    (imm16),
    .jidx26   (jidx26),
    .rs_val   (rs_val),
    .pc_plus4 (pc_plus4),
    .target   (target),
    .misalign (misalign)
`ifdef NPC_PERF_EN
    ,
    .taken    (taken)
`endif
  );

  // halt_req outranks a misaligned target, which in turn blocks the PC update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NPC_ST_RUN;
      pc_q     <= PC_RESET;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        NPC_ST_RUN: begin
          if (halt_req) begin
            state_q  <= NPC_ST_HALT;
            halted_q <= 1'b1;
          end else if (pc_en) begin
            if (misalign) begin
              state_q  <= NPC_ST_FAULT;
              halted_q <= 1'b1;
              fault_q  <= 1'b1;
            end else begin
              pc_q <= target;
            end
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign pc     = pc_q;
  assign halted = halted_q;
  assign fault  = fault_q;

`ifdef NPC_PERF_EN
  logic        commit;
  logic        is_branch;
  logic        is_jump;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] jmp_cnt_q, jmp_cnt_d;

  assign commit    = (state_q == NPC_ST_RUN) && pc_en && !halt_req && !misalign;
  assign is_branch = (npc_op_e'(npc_op) == NPC_BRANCH);
  assign is_jump   = (npc_op_e'(npc_op) == NPC_JUMP) || (npc_op_e'(npc_op) == NPC_JR);
  assign br_cnt_d  = br_cnt_q + 32'd1;
  assign jmp_cnt_d = jmp_cnt_q + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      jmp_cnt_q <= '0;
    end else if (commit) begin
      if (is_branch && taken) br_cnt_q <= br_cnt_d;
      if (is_jump)            jmp_cnt_q <= jmp_cnt_d;
    end
  end

  assign br_taken_cnt = br_cnt_q;
  assign jump_cnt     = jmp_cnt_q;
`endif

endmodule

// File: tb/tb_npc_unit.sv
// Directed bench for npc_unit; counter checks compile in when NPC_PERF_EN is defined.
module tb_npc_unit;
  import npc_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        pc_en;
  logic [1:0]  npc_op;
  logic        br_ne;
  logic        zero;
  logic [15:0] imm16;
  logic [25:0] jidx26;
  logic [31:0] rs_val;
  logic        halt_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
`ifdef NPC_PERF_EN
  logic [31:0] br_taken_cnt;
  logic [31:0] jump_cnt;
`endif

  int total = 0;
  int bad   = 0;

  npc_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_en    (pc_en),
    .npc_op   (npc_op),
    .br_ne    (br_ne),
    .zero     (zero),
    .imm16    (imm16),
    .jidx26   (jidx26),
    .rs_val   (rs_val),
    .halt_req (halt_req),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .halted   (halted),
    .fault    (fault)
`ifdef NPC_PERF_EN
    ,
    .br_taken_cnt (br_taken_cnt),
    .jump_cnt     (jump_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] op, input logic ne, input logic z,
                       input logic [15:0] imm, input logic [25:0] jidx, input logic [31:0] rs,
                       input logic hreq);
    pc_en = en; npc_op = op; br_ne = ne; zero = z;
    imm16 = imm; jidx26 = jidx; rs_val = rs; halt_req = hreq;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, NPC_PLUS4, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    // 1: reset state, then sequential flow
    chk("reset_pc", pc, 32'h0000_3000);
    chk("reset_halted", {31'b0, halted}, 32'd0);
    chk("reset_fault", {31'b0, fault}, 32'd0);
    cyc();
    rst_n = 1'b1;
    drive(1'b1, NPC_PLUS4, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    cyc(); chk("plus4_1", pc, 32'h0000_3004);
    cyc(); chk("plus4_2", pc, 32'h0000_3008);
    cyc(); chk("plus4_3", pc, 32'h0000_300C);
    chk("pc_plus4_comb", pc_plus4, 32'h0000_3010);
    cyc(); chk("plus4_4", pc, 32'h0000_3010);

    // 2: beq taken backwards, then not taken
    drive(1'b1, NPC_BRANCH, 1'b0, 1'b1, 16'hFFFC, 26'h0, 32'h0, 1'b0);
    cyc(); chk("beq_taken", pc, 32'h0000_3004);
    drive(1'b1, NPC_JR, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_3010, 1'b0);
    cyc(); chk("jr_3010", pc, 32'h0000_3010);
    drive(1'b1, NPC_BRANCH, 1'b0, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1'b0);
    cyc(); chk("beq_not_taken", pc, 32'h0000_3014);

    // 3: bne taken / not taken, jump
    rst_pulse();
    chk("rst_pulse_pc", pc, 32'h0000_3000);
    drive(1'b1, NPC_BRANCH, 1'b1, 1'b0, 16'h0002, 26'h0, 32'h0, 1'b0);
    cyc(); chk("bne_taken", pc, 32'h0000_300C);
    drive(1'b1, NPC_BRANCH, 1'b1, 1'b1, 16'h0002, 26'h0, 32'h0, 1'b0);
    cyc(); chk("bne_not_taken", pc, 32'h0000_3010);
    rst_pulse();
    drive(1'b1, NPC_JUMP, 1'b0, 1'b0, 16'h0, 26'h0000C04, 32'h0, 1'b0);
    cyc(); chk("jump", pc, 32'h0000_3010);

    // 4: stall, then wrap at top of address space
    drive(1'b0, NPC_BRANCH, 1'b0, 1'b1, 16'hFFFC, 26'h0, 32'h0, 1'b0);
    cyc(); chk("stall_1", pc, 32'h0000_3010);
    cyc(); chk("stall_2", pc, 32'h0000_3010);
    drive(1'b1, NPC_JR, 1'b0, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0);
    cyc(); chk("jr_top", pc, 32'hFFFF_FFFC);
    chk("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
    drive(1'b1, NPC_PLUS4, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    cyc(); chk("plus4_wrap", pc, 32'h0000_0000);
    chk("wrap_no_fault", {31'b0, fault}, 32'd0);
    drive(1'b1, NPC_BRANCH, 1'b0, 1'b1, 16'h8000, 26'h0, 32'h0, 1'b0);
    cyc(); chk("branch_wrap", pc, 32'hFFFE_0004);

    // 5: misaligned jr faults, halt outranks fault, async reset
    drive(1'b1, NPC_JR, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_3002, 1'b0);
    cyc();
    chk("fault_pc_frozen", pc, 32'hFFFE_0004);
    chk("fault_flag", {31'b0, fault}, 32'd1);
    chk("fault_halted", {31'b0, halted}, 32'd1);
    drive(1'b1, NPC_PLUS4, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    cyc(); cyc();
    chk("fault_ignores_ops", pc, 32'hFFFE_0004);
    chk("fault_sticky", {31'b0, fault}, 32'd1);
    rst_pulse();
    chk("fault_cleared", {31'b0, fault}, 32'd0);
    drive(1'b1, NPC_JR, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_3002, 1'b1);
    cyc();
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_no_fault", {31'b0, fault}, 32'd0);
    chk("halt_pc", pc, 32'h0000_3000);
    drive(1'b1, NPC_PLUS4, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    cyc(); chk("halt_terminal", pc, 32'h0000_3000);
    rst_pulse();
    chk("halt_cleared", {31'b0, halted}, 32'd0);
    cyc(); cyc();
    chk("run_after_halt", pc, 32'h0000_3008);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pc", pc, 32'h0000_3000);
    rst_n = 1'b1;

`ifdef NPC_PERF_EN
    // 6: event counters
    cyc();
    rst_pulse();
    chk("cnt_reset_br", br_taken_cnt, 32'd0);
    chk("cnt_reset_jmp", jump_cnt, 32'd0);
    drive(1'b1, NPC_BRANCH, 1'b0, 1'b1, 16'h0001, 26'h0, 32'h0, 1'b0);
    cyc(); cyc();
    chk("cnt_branch_pc", pc, 32'h0000_3010);
    drive(1'b1, NPC_BRANCH, 1'b0, 1'b0, 16'h0001, 26'h0, 32'h0, 1'b0);
    cyc();
    drive(1'b1, NPC_JUMP, 1'b0, 1'b0, 16'h0, 26'h0000C00, 32'h0, 1'b0);
    cyc();
    drive(1'b1, NPC_JR, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_3100, 1'b0);
    cyc();
    drive(1'b0, NPC_JUMP, 1'b0, 1'b0, 16'h0, 26'h0000C00, 32'h0, 1'b0);
    cyc();
    chk("cnt_pc", pc, 32'h0000_3100);
    chk("cnt_br_taken", br_taken_cnt, 32'd2);
    chk("cnt_jump", jump_cnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
